// File: rtl/geo_pixel_writer.sv
// rtl/geo_pixel_writer.sv - pixel_cmd consumer: 16-bit word RMW at 1/2/4/8/16 bpp plus copy/paste, mask and ARGB state
// Optional: define GEO_PXWR_COLLISION_EN to build the PXWRI_M collision counter.
module geo_pixel_writer #(
  parameter int ADDR_W = 20,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pixel_cmd_rdy,
  input  logic [39:0]       pixel_cmd,
  output logic              draw_busy,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd_req,
  output logic              mem_wr_req,
  output logic [15:0]       mem_wr_data,
  input  logic              mem_ack,
  input  logic              mem_rd_valid,
  input  logic [15:0]       mem_rd_data,
  output logic [31:0]       argb,
  output logic [CNT_W-1:0]  collision_cnt
);

  localparam logic [3:0] CMD_PXWRI     = 4'd1;
  localparam logic [3:0] CMD_PXWRI_M   = 4'd2;
  localparam logic [3:0] CMD_PXPASTE   = 4'd3;
  localparam logic [3:0] CMD_PXPASTE_M = 4'd4;
  localparam logic [3:0] CMD_PXCOPY    = 4'd6;
  localparam logic [3:0] CMD_SETARGB   = 4'd7;
  localparam logic [3:0] CMD_RST_WRI_M = 4'd10;
  localparam logic [3:0] CMD_RST_PST_M = 4'd11;

  typedef enum logic [1:0] {IDLE, RD_REQ, RD_WAIT, WR_REQ} state_t;
  state_t state, state_nxt;

  logic [3:0]  cmd_q, code_q, idx_q;
  logic [7:0]  colour_q, wr_mask, pst_mask;
  logic [15:0] paste_buf;

  function automatic logic [15:0] field_mask(input logic [3:0] code);
    case (code)
      4'd0:    field_mask = 16'h0001;
      4'd1:    field_mask = 16'h0003;
      4'd3:    field_mask = 16'h000F;
      4'd7:    field_mask = 16'h00FF;
      default: field_mask = 16'hFFFF;
    endcase
  endfunction

  // Power-of-two bpp makes (idx*bpp) mod 16 a plain bit-select of idx.
  function automatic logic [3:0] field_shift(input logic [3:0] code, input logic [3:0] idx);
    case (code)
      4'd0:    field_shift = idx;
      4'd1:    field_shift = {idx[2:0], 1'b0};
      4'd3:    field_shift = {idx[1:0], 2'b00};
      4'd7:    field_shift = {idx[0], 3'b000};
      default: field_shift = 4'd0;
    endcase
  endfunction

  logic [3:0]  in_cmd, in_code;
  logic [15:0] in_mask, in_src;
  logic        accept, in_bpp_ok, in_is_mem, paste_skip, start, start_direct;

  assign in_cmd     = pixel_cmd[39:36];
  assign in_code    = pixel_cmd[27:24];
  assign in_mask    = field_mask(in_code);
  assign in_src     = (in_cmd == CMD_PXWRI || in_cmd == CMD_PXWRI_M) ? {8'h00, pixel_cmd[35:28]} : paste_buf;
  assign accept     = pixel_cmd_rdy && !draw_busy && (state == IDLE);
  assign in_bpp_ok  = in_code inside {4'd0, 4'd1, 4'd3, 4'd7, 4'd15};
  assign in_is_mem  = in_cmd inside {CMD_PXWRI, CMD_PXWRI_M, CMD_PXPASTE, CMD_PXPASTE_M, CMD_PXCOPY};
  assign paste_skip = (in_cmd == CMD_PXPASTE_M) && (((paste_buf ^ {8'h00, pst_mask}) & in_mask) == 16'h0000);
  assign start      = accept && in_is_mem && in_bpp_ok && !paste_skip;
  assign start_direct = start && (in_code == 4'd15) && (in_cmd != CMD_PXCOPY);

  logic [15:0] cur_mask, cur_src, old_field, merged;
  logic [3:0]  cur_shift;
  logic        rd_take;

  assign cur_mask  = field_mask(code_q);
  assign cur_shift = field_shift(code_q, idx_q);
  assign cur_src   = (cmd_q == CMD_PXWRI || cmd_q == CMD_PXWRI_M) ? {8'h00, colour_q} : paste_buf;
  assign old_field = (mem_rd_data >> cur_shift) & cur_mask;
  assign merged    = (mem_rd_data & ~(cur_mask << cur_shift)) | ((cur_src & cur_mask) << cur_shift);
  assign rd_take   = mem_rd_valid && ((state == RD_WAIT) || (state == RD_REQ && mem_ack));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      draw_busy <= 1'b0;
    end else begin
      state     <= state_nxt;
      draw_busy <= (state_nxt != IDLE);
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = start_direct ? WR_REQ : RD_REQ;
      RD_REQ:  if (mem_ack) state_nxt = mem_rd_valid ? ((cmd_q == CMD_PXCOPY) ? IDLE : WR_REQ) : RD_WAIT;
      RD_WAIT: if (mem_rd_valid) state_nxt = (cmd_q == CMD_PXCOPY) ? IDLE : WR_REQ;
      WR_REQ:  if (mem_ack) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    mem_rd_req = (state == RD_REQ);
    mem_wr_req = (state == WR_REQ);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cmd_q       <= 4'd0;
      code_q      <= 4'd0;
      idx_q       <= 4'd0;
      colour_q    <= 8'h00;
      mem_addr    <= '0;
      mem_wr_data <= 16'h0000;
      argb        <= 32'h0;
      wr_mask     <= 8'h00;
      pst_mask    <= 8'h00;
      paste_buf   <= 16'h0000;
    end else begin
      if (accept) begin
        case (in_cmd)
          CMD_SETARGB:   argb     <= pixel_cmd[31:0];
          CMD_RST_WRI_M: wr_mask  <= pixel_cmd[31:24];
          CMD_RST_PST_M: pst_mask <= pixel_cmd[31:24];
          default: ;
        endcase
      end
      if (start) begin
        cmd_q    <= in_cmd;
        code_q   <= in_code;
        idx_q    <= pixel_cmd[23:20];
        colour_q <= pixel_cmd[35:28];
        mem_addr <= ADDR_W'({pixel_cmd[19:1], 1'b0});
      end
      if (start_direct) mem_wr_data <= in_src;
      if (rd_take) begin
        if (cmd_q == CMD_PXCOPY) paste_buf <= old_field;
        else                     mem_wr_data <= merged;
      end
    end
  end

  wire unused_addr_lsb = pixel_cmd[0];

`ifdef GEO_PXWR_COLLISION_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      collision_cnt <= '0;
    end else if (accept && in_cmd == CMD_RST_WRI_M) begin
      collision_cnt <= '0;
    end else if (rd_take && cmd_q == CMD_PXWRI_M &&
                 old_field != ({8'h00, wr_mask} & cur_mask) && collision_cnt != '1) begin
      collision_cnt <= collision_cnt + 1'b1;
    end
  end
`else
  assign collision_cnt = '0;
  wire unused_wr_mask = ^wr_mask;
`endif

endmodule
